rect_fill_generator: RTL

// - Generator stage downstream of the command FIFO: pops 8-bit parameter bytes, assembles one rectangle

---
 rtl/gfx_pkg.sv | 44 ++++
 rtl/gfx_byte_collector.sv | 69 ++++++
 rtl/rect_fill_generator.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/gfx_pkg.sv
// Shared definitions for the rectangle generator: state encoding, command byte layout, widths.
// Command length depends on RECT_OUTLINE_EN (adds a MODE byte when defined).
package gfx_pkg;

    localparam int DATA_W  = 8;
    localparam int COORD_W = 8;
    localparam int COLOR_W = 8;
    localparam int BCNT_W  = 3;

    localparam logic [COORD_W-1:0] X_MAX_DEF = 8'd159;
    localparam logic [COORD_W-1:0] Y_MAX_DEF = 8'd119;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_DRAW = 1'b1
    } state_e;

    localparam int IDX_X0    = 0;
    localparam int IDX_Y0    = 1;
    localparam int IDX_X1    = 2;
    localparam int IDX_Y1    = 3;
    localparam int IDX_COLOR = 4;
    localparam int IDX_MODE  = 5;

`ifdef RECT_OUTLINE_EN
    localparam int RECT_NBYTES = 6;
`else
    localparam int RECT_NBYTES = 5;
`endif

    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(RECT_NBYTES - 1);

    function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                       input logic [COORD_W-1:0] lim);
        logic [COORD_W-1:0] r;
        if (v > lim) begin
            r = lim;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/gfx_byte_collector.sv
// Pops parameter bytes from the command FIFO into the command register file.
// Flags cmd_ready_o in the cycle the final byte is accepted; params_o already includes that byte.
module gfx_byte_collector
    import gfx_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst_,
    input  logic [DATA_W-1:0]                      in_data,
    input  logic                                   in_rts,
    output logic                                   in_rtr,
    input  logic                                   release_i,
    output logic                                   cmd_ready_o,
    output logic [RECT_NBYTES-1:0][DATA_W-1:0]     params_o
);

    logic [BCNT_W-1:0]                  byte_cnt_q, byte_cnt_d;
    logic [RECT_NBYTES-1:0][DATA_W-1:0] params_q, params_d;
    logic                               drawing_q, drawing_d;
    logic                               in_rtr_q;
    logic                               accept_s;

    assign accept_s    = in_rts & in_rtr_q;
    assign cmd_ready_o = accept_s && (byte_cnt_q == BCNT_LAST);

    // Next-state for byte counter, parameter bytes and the drawing lockout.
    always_comb begin
        params_d   = params_q;
        byte_cnt_d = byte_cnt_q;
        drawing_d  = drawing_q;
        if (accept_s) begin
            for (int i = 0; i < RECT_NBYTES; i++) begin
                if (byte_cnt_q == BCNT_W'(i)) begin
                    params_d[i] = in_data;
                end else begin
                    params_d[i] = params_q[i];
                end
            end
            if (byte_cnt_q == BCNT_LAST) begin
                byte_cnt_d = 3'd0;
                drawing_d  = 1'b1;
            end else begin
                byte_cnt_d = byte_cnt_q + 3'd1;
            end
        end else if (release_i) begin
            drawing_d = 1'b0;
        end else begin
            drawing_d = drawing_q;
        end
    end

    // Collector registers; in_rtr stays low out of reset until the first edge.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            byte_cnt_q <= 3'd0;
            params_q   <= '0;
            drawing_q  <= 1'b0;
            in_rtr_q   <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            params_q   <= params_d;
            drawing_q  <= drawing_d;
            in_rtr_q   <= ~drawing_d;
        end
    end

    assign in_rtr   = in_rtr_q;
    assign params_o = params_d;

endmodule

// File: rtl/rect_fill_generator.sv
// Rectangle generator: collects a command, normalises it, and streams one pixel per handshake.
// Optional outline mode (sixth MODE byte) is built when RECT_OUTLINE_EN is defined.
module rect_fill_generator
    import gfx_pkg::*;
#(
    parameter logic [COORD_W-1:0] X_MAX = X_MAX_DEF,
    parameter logic [COORD_W-1:0] Y_MAX = Y_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_rts,
    output logic               in_rtr,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [COLOR_W-1:0] out_color,
    output logic               out_last,
    output logic               out_rts,
    input  logic               out_rtr,
    output logic               busy
);

    state_e                              state_q;
    logic [COORD_W-1:0]                  x_q, y_q;
    logic [COORD_W-1:0]                  xmin_q, xmax_q, ymin_q, ymax_q;
    logic [COLOR_W-1:0]                  color_q;
    logic                                out_rts_q, out_last_q, busy_q;
    logic                                outline_q;

    logic                                cmd_ready_s, release_s, in_fire_s, out_fire_s;
    logic [RECT_NBYTES-1:0][DATA_W-1:0]  params_s;
    logic [COORD_W-1:0]                  x0_s, y0_s, x1_s, y1_s;
    logic [COORD_W-1:0]                  nxmin_s, nxmax_s, nymin_s, nymax_s;
    logic                                nlast_s, nout_s;
    logic [COORD_W-1:0]                  nx_s, ny_s;
    logic                                skip_s, step_last_s;

    gfx_byte_collector u_collector (
        .clk         (clk),
        .rst_        (rst_),
        .in_data     (in_data),
        .in_rts      (in_rts),
        .in_rtr      (in_rtr),
        .release_i   (release_s),
        .cmd_ready_o (cmd_ready_s),
        .params_o    (params_s)
    );

    assign in_fire_s  = in_rts & in_rtr;
    assign out_fire_s = out_rts_q & out_rtr;
    assign release_s  = out_fire_s & out_last_q;

    // Clamp then order the corners so the raster always runs min->max.
    always_comb begin
        x0_s    = clamp_coord(params_s[IDX_X0], X_MAX);
        y0_s    = clamp_coord(params_s[IDX_Y0], Y_MAX);
        x1_s    = clamp_coord(params_s[IDX_X1], X_MAX);
        y1_s    = clamp_coord(params_s[IDX_Y1], Y_MAX);
        nxmin_s = (x0_s < x1_s) ? x0_s : x1_s;
        nxmax_s = (x0_s < x1_s) ? x1_s : x0_s;
        nymin_s = (y0_s < y1_s) ? y0_s : y1_s;
        nymax_s = (y0_s < y1_s) ? y1_s : y0_s;
        nlast_s = (nxmin_s == nxmax_s) && (nymin_s == nymax_s);
    end

`ifdef RECT_OUTLINE_EN
    assign nout_s = params_s[IDX_MODE][0];
`else
    assign nout_s = 1'b0;
`endif

    // Next raster position; interior outline rows jump straight from xmin to xmax.
    always_comb begin
        nx_s   = x_q;
        ny_s   = y_q;
        skip_s = outline_q && (y_q != ymin_q) && (y_q != ymax_q) &&
                 (x_q == xmin_q) && (xmin_q != xmax_q);
        if (skip_s) begin
            nx_s = xmax_q;
        end else if (x_q < xmax_q) begin
            nx_s = x_q + 8'd1;
        end else begin
            nx_s = xmin_q;
            ny_s = y_q + 8'd1;
        end
        step_last_s = (nx_s == xmax_q) && (ny_s == ymax_q);
    end

    // Control FSM with registered pixel outputs.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= S_LOAD;
            x_q        <= 8'd0;
            y_q        <= 8'd0;
            xmin_q     <= 8'd0;
            xmax_q     <= 8'd0;
            ymin_q     <= 8'd0;
            ymax_q     <= 8'd0;
            color_q    <= 8'd0;
            outline_q  <= 1'b0;
            out_rts_q  <= 1'b0;
            out_last_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_fire_s) begin
                        busy_q <= 1'b1;
                    end
                    if (cmd_ready_s) begin
                        xmin_q     <= nxmin_s;
                        xmax_q     <= nxmax_s;
                        ymin_q     <= nymin_s;
                        ymax_q     <= nymax_s;
                        x_q        <= nxmin_s;
                        y_q        <= nymin_s;
                        color_q    <= params_s[IDX_COLOR];
                        outline_q  <= nout_s;
                        out_rts_q  <= 1'b1;
                        out_last_q <= nlast_s;
                        state_q    <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (out_fire_s) begin
                        if (out_last_q) begin
                            out_rts_q  <= 1'b0;
                            out_last_q <= 1'b0;
                            busy_q     <= 1'b0;
                            state_q    <= S_LOAD;
                        end else begin
                            x_q        <= nx_s;
                            y_q        <= ny_s;
                            out_last_q <= step_last_s;
                        end
                    end
                end
                default: begin
                    state_q   <= S_LOAD;
                    out_rts_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_color = color_q;
    assign out_last  = out_last_q;
    assign out_rts   = out_rts_q;
    assign busy      = busy_q;

endmodule
